// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, parity modes and helpers for the UART blocks
package uart_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_REQ        = 3'd1;
    localparam logic [2:0] ST_WAIT_VALID = 3'd2;
    localparam logic [2:0] ST_START      = 3'd3;
    localparam logic [2:0] ST_DATA       = 3'd4;
    localparam logic [2:0] ST_PARITY     = 3'd5;
    localparam logic [2:0] ST_STOP       = 3'd6;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Never returns less than 1 so that a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter; bit_done marks the last cycle of each serial bit
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_done
);

    localparam int               CNT_W    = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_done = (cnt_q == CNT_LAST);

    // Wrapping on bit_done keeps consecutive bits in one state exactly CLKS_PER_BIT apart.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - UART transmitter popping bytes from the TX FIFO and framing them onto tx
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic                 fifo_empty,
    input  logic                 fifo_out_valid,
    input  logic [DATA_BITS-1:0] fifo_output,
    output logic                 fifo_read_en,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int               IDX_W     = clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [1:0]       WAIT_LAST = 2'd1;

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [1:0]           wait_q, wait_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 rd_q, rd_d;
    logic                 busy_q, busy_d;
    logic                 bit_done;
    logic                 baud_clr;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (baud_clr),
        .bit_done (bit_done)
    );

    // Restarting the baud count on every state change aligns each bit with its state entry.
    assign baud_clr = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                wait_d  = '0;
                state_d = ST_WAIT_VALID;
            end
            ST_WAIT_VALID: begin
                if (fifo_out_valid) begin
                    shift_d = fifo_output;
                    par_d   = (^fifo_output) ^ (PARITY == PAR_ODD);
                    state_d = ST_START;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        tx_d   = 1'b1;
        rd_d   = (state_d == ST_REQ);
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
        end
    end

    assign tx           = tx_q;
    assign fifo_read_en = rd_q;
    assign tx_busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - bench for uart_tx_drain with no/even/odd parity instances and FIFO models
module tb_uart_tx_drain;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en    [3] = '{1'b1, 1'b1, 1'b1};
    logic       withhold [3] = '{1'b0, 1'b0, 1'b0};
    logic       fvalid   [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] fout     [3] = '{8'h00, 8'h00, 8'h00};
    logic       fempty   [3];
    logic       rd_en    [3];
    logic       tx_w     [3];
    logic       busy     [3];
    logic [7:0] mem      [3][32];
    int         head     [3] = '{0, 0, 0};
    int         tail     [3] = '{0, 0, 0};
    int         rd_cnt   [3] = '{0, 0, 0};
    int         busy_cnt [3] = '{0, 0, 0};
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    // Instance g runs with parity mode g: 0 none, 1 even, 2 odd.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign fempty[g] = (head[g] == tail[g]);
        uart_tx_drain #(
            .CLKS_PER_BIT(C),
            .DATA_BITS   (8),
            .PARITY      (g)
        ) dut (
            .clk            (clk),
            .rst            (rst),
            .tx_en          (tx_en[g]),
            .fifo_empty     (fempty[g]),
            .fifo_out_valid (fvalid[g]),
            .fifo_output    (fout[g]),
            .fifo_read_en   (rd_en[g]),
            .tx             (tx_w[g]),
            .tx_busy        (busy[g])
        );
    end

    // FIFO model: a read request seen on a clock edge yields a one-cycle valid pulse next cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            fvalid[k] <= 1'b0;
            if (rd_en[k] && (head[k] != tail[k]) && !withhold[k]) begin
                fvalid[k] <= 1'b1;
                fout[k]   <= mem[k][head[k] % 32];
                head[k]   <= head[k] + 1;
            end
            if (rd_en[k]) rd_cnt[k] <= rd_cnt[k] + 1;
            if (busy[k])  busy_cnt[k] <= busy_cnt[k] + 1;
        end
    end

    function automatic int frame_len(input int par);
        return (par == 0) ? 10 : 11;
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int par, input int i);
        int ones;
        ones = 0;
        for (int j = 0; j < 8; j++) ones = ones + (d[j] ? 1 : 0);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (par == 1 && i == 9) return ((ones % 2) == 1);
        if (par == 2 && i == 9) return ((ones % 2) == 0);
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d);
        mem[k][tail[k] % 32] = d;
        tail[k] = tail[k] + 1;
    endtask

    task automatic wait_start(input int k);
        int n;
        n = 0;
        while (tx_w[k] !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("start_seen%0d", k), {31'd0, tx_w[k]}, 32'd0);
    endtask

    // Called at the first sampled cycle of the start bit; returns one cycle after the stop bit.
    task automatic check_frame(input int k, input logic [7:0] d, input int drop_at);
        for (int i = 0; i < frame_len(k); i++) begin
            for (int c = 0; c < C; c++) begin
                if (i * C + c == drop_at) tx_en[k] = 1'b0;
                chk($sformatf("frame%0d_%02h_bit%0d", k, d, i), {31'd0, tx_w[k]},
                    {31'd0, frame_bit(d, k, i)});
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_req(input int k, input string tag);
        int n;
        n = 0;
        while (rd_en[k] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, rd_en[k]}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before test completion");
        $fatal(1);
    end

    initial begin
        int r0;
        int b0;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_tx%0d", k),   {31'd0, tx_w[k]},  32'd1);
            chk($sformatf("rst_busy%0d", k), {31'd0, busy[k]},  32'd0);
            chk($sformatf("rst_rd%0d", k),   {31'd0, rd_en[k]}, 32'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_empty_busy", {31'd0, busy[0]}, 32'd0);

        // Single byte, exact request-to-start latency and busy length.
        r0 = rd_cnt[0];
        b0 = busy_cnt[0];
        push(0, 8'hA5);
        @(negedge clk);
        chk("req_pulse", {31'd0, rd_en[0]}, 32'd1);
        chk("req_busy",  {31'd0, busy[0]},  32'd1);
        chk("req_tx",    {31'd0, tx_w[0]},  32'd1);
        @(negedge clk);
        chk("wait_rd_low", {31'd0, rd_en[0]}, 32'd0);
        chk("wait_tx",     {31'd0, tx_w[0]},  32'd1);
        @(negedge clk);
        check_frame(0, 8'hA5, -1);
        chk("a5_busy_after", {31'd0, busy[0]}, 32'd0);
        chk("a5_tx_after",   {31'd0, tx_w[0]}, 32'd1);
        chk("a5_busy_cycles", busy_cnt[0] - b0, 32'd42);
        chk("a5_rd_pulses",   rd_cnt[0] - r0,   32'd1);

        // Back-to-back frames with a three-cycle idle gap.
        r0 = rd_cnt[0];
        push(0, 8'h55);
        push(0, 8'h0F);
        wait_start(0);
        check_frame(0, 8'h55, -1);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("gap_tx%0d", g), {31'd0, tx_w[0]}, 32'd1);
            @(negedge clk);
        end
        check_frame(0, 8'h0F, -1);
        chk("b2b_rd_pulses", rd_cnt[0] - r0, 32'd2);

        // Parity frames, directed then random bytes on every instance.
        push(2, 8'h07);
        wait_start(2);
        check_frame(2, 8'h07, -1);
        push(1, 8'h07);
        wait_start(1);
        check_frame(1, 8'h07, -1);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                d = 8'($urandom);
                push(k, d);
                wait_start(k);
                check_frame(k, d, -1);
            end
        end

        // FIFO withholds valid: give up after two cycles, then retry.
        withhold[0] = 1'b1;
        push(0, 8'hC3);
        wait_req(0, "wd_req");
        @(negedge clk);
        chk("wd_w0_busy", {31'd0, busy[0]}, 32'd1);
        chk("wd_w0_tx",   {31'd0, tx_w[0]}, 32'd1);
        @(negedge clk);
        chk("wd_w1_busy", {31'd0, busy[0]},  32'd1);
        chk("wd_w1_rd",   {31'd0, rd_en[0]}, 32'd0);
        @(negedge clk);
        chk("wd_idle_busy", {31'd0, busy[0]},  32'd0);
        chk("wd_idle_tx",   {31'd0, tx_w[0]},  32'd1);
        chk("wd_idle_rd",   {31'd0, rd_en[0]}, 32'd0);
        @(negedge clk);
        chk("wd_retry", {31'd0, rd_en[0]}, 32'd1);
        withhold[0] = 1'b0;
        wait_start(0);
        check_frame(0, 8'hC3, -1);

        // Asynchronous reset in data bit 3 drops the byte; the next one is then requested.
        push(0, 8'hFF);
        push(0, 8'h11);
        wait_start(0);
        repeat (C + 3 * C + 1) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy[0]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_tx",   {31'd0, tx_w[0]}, 32'd1);
        chk("async_rst_busy", {31'd0, busy[0]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_req(0, "post_rst_req");
        wait_start(0);
        check_frame(0, 8'h11, -1);

        // tx_en drops during the stop bit: frame completes, nothing further is popped.
        r0 = rd_cnt[0];
        push(0, 8'h3C);
        push(0, 8'h99);
        push(0, 8'h42);
        wait_start(0);
        check_frame(0, 8'h3C, 9 * C + 1);
        chk("dis_busy_after", {31'd0, busy[0]}, 32'd0);
        repeat (20) @(negedge clk);
        chk("dis_rd_pulses", rd_cnt[0] - r0, 32'd1);
        chk("dis_busy_hold", {31'd0, busy[0]}, 32'd0);
        chk("dis_tx_hold",   {31'd0, tx_w[0]}, 32'd1);
        tx_en[0] = 1'b1;
        wait_start(0);
        check_frame(0, 8'h99, -1);
        wait_start(0);
        check_frame(0, 8'h42, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
